// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-side arbiter.
// Holds the burst-lock state encoding and a constant-foldable clog2.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_wr_arb_rr_pick.sv
// Rotating-priority picker: first eligible requester at or after ptr.
// Eligibility is req & mask; outputs a one-hot winner and its index.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic [N-1:0]  mask,
  output logic [N-1:0]  win,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [N-1:0] elig;

  assign elig = req & mask;

  always_comb begin : pick
    int k;
    logic [N-1:0] one_k;
    k     = 0;
    one_k = '0;
    win   = '0;
    idx   = '0;
    any   = 1'b0;
    for (int i = 0; i < N; i++) begin
      k     = (int'(ptr) + i) % N;
      one_k = N'(1) << k;
      if (!any && |(elig & one_k)) begin
        win = one_k;
        idx = IW'(k);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arb.sv
// Round-robin arbiter sharing one sync FIFO write port among N_REQ sources.
// Optional burst lock is compiled in with `define FIFO_ARB_BURST_EN.
module fifo_wr_arb #(
  parameter int N_REQ     = 4,
  parameter int WIDTH     = 16,
  parameter int MAX_BURST = 8,
  parameter int ID_W      = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ-1:0]       last,
  input  logic [N_REQ*WIDTH-1:0] din,
  output logic [N_REQ-1:0]       gnt,
  input  logic                   fifo_ful,
  output logic                   fifo_wr,
  output logic [WIDTH-1:0]       fifo_din,
  output logic [ID_W-1:0]        grant_id,
  output logic                   burst_active
);

  import fifo_arb_pkg::*;

  logic [ID_W-1:0]  rr_q;
  logic [ID_W-1:0]  rr_d;
  logic [ID_W-1:0]  sel_ptr;
  logic [N_REQ-1:0] sel_mask;
  logic [N_REQ-1:0] pick_win;
  logic [ID_W-1:0]  pick_idx;
  logic             pick_any;
  logic             accept;

  function automatic logic [ID_W-1:0] nxt_idx(
    input logic [ID_W-1:0] i
  );
    return (int'(i) == N_REQ - 1) ? '0 : i + 1'b1;
  endfunction

  rr_pick #(
    .N  (N_REQ),
    .IW (ID_W)
  ) u_pick (
    .req  (req),
    .ptr  (sel_ptr),
    .mask (sel_mask),
    .win  (pick_win),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  // Full is treated conservatively: no grant even if the FIFO drains now.
  assign gnt     = (pick_any && !fifo_ful) ? pick_win : '0;
  assign accept  = |gnt;
  assign fifo_wr = accept;

  logic [WIDTH-1:0] din_acc [N_REQ+1];

  assign din_acc[0] = '0;

  for (genvar g = 0; g < N_REQ; g++) begin : g_mux
    assign din_acc[g+1] = din_acc[g]
                        | (din[g*WIDTH +: WIDTH] & {WIDTH{gnt[g]}});
  end

  assign fifo_din = din_acc[N_REQ];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_q     <= '0;
      grant_id <= '0;
    end else begin
      rr_q <= rr_d;
      if (accept) grant_id <= pick_idx;
    end
  end

`ifdef FIFO_ARB_BURST_EN
  localparam int CNT_W = clog2(MAX_BURST + 1);

  arb_state_e       state_q;
  arb_state_e       state_d;
  logic [ID_W-1:0]  owner_q;
  logic [ID_W-1:0]  owner_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [N_REQ-1:0] own_oh;
  logic             own_req;
  logic             last_hit;
  logic             cap_hit;

  assign own_oh       = N_REQ'(1) << owner_q;
  assign own_req      = |(req & own_oh);
  assign last_hit     = |(last & gnt);
  assign cap_hit      = int'(cnt_q) >= MAX_BURST - 1;
  assign sel_mask     = (state_q == BURST) ? own_oh : '1;
  assign sel_ptr      = (state_q == BURST) ? owner_q : rr_q;
  assign burst_active = (state_q == BURST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    rr_d    = rr_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (!last_hit && MAX_BURST > 1) begin
            state_d = BURST;
            owner_d = pick_idx;
            cnt_d   = CNT_W'(1);
          end else begin
            rr_d = nxt_idx(pick_idx);
          end
        end
      end
      BURST: begin
        // Owner dropping req releases the lock with a one-cycle gap.
        if (!own_req) begin
          state_d = IDLE;
          cnt_d   = '0;
          rr_d    = nxt_idx(owner_q);
        end else if (accept) begin
          if (last_hit || cap_hit) begin
            state_d = IDLE;
            cnt_d   = '0;
            rr_d    = nxt_idx(owner_q);
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end
`else
  logic unused_cfg;

  assign unused_cfg   = ^last ^ (MAX_BURST > 1);
  assign sel_mask     = '1;
  assign sel_ptr      = rr_q;
  assign burst_active = 1'b0;
  assign rr_d         = accept ? nxt_idx(pick_idx) : rr_q;
`endif

endmodule
